// File: rtl/canvas_pkg.sv
// Shared pixel packet types for the painting pipeline.
// One packet carries the X/Y position and the {R,G,B} colour.
package canvas_pkg;

  localparam int COLOUR_W = 3;
  localparam int PIXEL_W  = 19;

  typedef struct packed {
    logic [7:0]          x;
    logic [7:0]          y;
    logic [COLOUR_W-1:0] colour;
  } pixel_t;

endpackage

// File: rtl/pixel_queue_mem.sv
// Packet storage for pixel_queue: one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module pixel_queue_mem
  import canvas_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  pixel_t            wdata,
  input  logic [ADDR_W-1:0] raddr,
  output pixel_t            rdata
);

  pixel_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pixel_queue.sv
// Elastic FWFT packet buffer between the brush/fill expander and the I2C
// register file, with back-to-back duplicate suppression and loss tracking.
module pixel_queue
  import canvas_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3,
  parameter int DEDUP  = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                push,
  input  logic [7:0]          x_in,
  input  logic [7:0]          y_in,
  input  logic [COLOUR_W-1:0] color_in,
  input  logic                pop,
  input  logic                clear,
  output logic [7:0]          x_out,
  output logic [7:0]          y_out,
  output logic [COLOUR_W-1:0] color_out,
  output logic                head_valid,
  output logic                full,
  output logic [ADDR_W:0]     count,
  output logic                overflow,
  output logic [7:0]          drop_count
);

  localparam logic [ADDR_W-1:0] PTR_ONE   = 1;
  localparam logic [ADDR_W:0]   CNT_ONE   = 1;
  localparam logic [ADDR_W:0]   DEPTH_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_q, count_nxt;
  logic              full_q, head_valid_q, overflow_q;
  logic [7:0]        drop_q;
  pixel_t            last_pkt;
  logic              last_valid;

  pixel_t in_pkt, head_pkt;
  logic   is_dup, pop_ok, push_ok, lose;

  assign in_pkt = '{x: x_in, y: y_in, colour: color_in};

  // A duplicate is judged against the last accepted push, even if popped since.
  assign is_dup  = (DEDUP != 0) && last_valid && (in_pkt == last_pkt);
  assign pop_ok  = pop && head_valid_q;
  assign push_ok = push && !is_dup && (!full_q || pop_ok);
  assign lose    = push && !is_dup && full_q && !pop;

  always_comb begin
    count_nxt = count_q;
    if (push_ok && !pop_ok) begin
      count_nxt = count_q + CNT_ONE;
    end else if (!push_ok && pop_ok) begin
      count_nxt = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      head_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
      last_pkt     <= '0;
      last_valid   <= 1'b0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      head_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
      last_valid   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr     <= wr_ptr + PTR_ONE;
        last_pkt   <= in_pkt;
        last_valid <= 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      if (lose) begin
        overflow_q <= 1'b1;
        if (drop_q != 8'hFF) begin
          drop_q <= drop_q + 8'd1;
        end
      end
      count_q      <= count_nxt;
      full_q       <= (count_nxt == DEPTH_CNT);
      head_valid_q <= (count_nxt != '0);
    end
  end

  pixel_queue_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push_ok && !clear),
    .waddr (wr_ptr),
    .wdata (in_pkt),
    .raddr (rd_ptr),
    .rdata (head_pkt)
  );

  // Head reads zero while empty so stale storage never leaks to the host.
  assign x_out      = head_valid_q ? head_pkt.x      : '0;
  assign y_out      = head_valid_q ? head_pkt.y      : '0;
  assign color_out  = head_valid_q ? head_pkt.colour : '0;
  assign head_valid = head_valid_q;
  assign full       = full_q;
  assign count      = count_q;
  assign overflow   = overflow_q;
  assign drop_count = drop_q;

endmodule

// File: tb/tb_pixel_queue.sv
// Self-checking bench for pixel_queue: directed scenarios plus random traffic,
// scored against a queue-based reference model and a pop-side scoreboard.
module tb_pixel_queue;
  import canvas_pkg::*;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                push = 1'b0, pop = 1'b0, clear = 1'b0;
  logic [7:0]          x_in = '0, y_in = '0;
  logic [COLOUR_W-1:0] color_in = '0;
  logic [7:0]          x_out, y_out;
  logic [COLOUR_W-1:0] color_out;
  logic                head_valid, full, overflow;
  logic [ADDR_W:0]     count;
  logic [7:0]          drop_count;

  pixel_queue #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .DEDUP(1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .x_in       (x_in),
    .y_in       (y_in),
    .color_in   (color_in),
    .pop        (pop),
    .clear      (clear),
    .x_out      (x_out),
    .y_out      (y_out),
    .color_out  (color_out),
    .head_valid (head_valid),
    .full       (full),
    .count      (count),
    .overflow   (overflow),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state: stored packets, loss status and last accepted push.
  pixel_t mdl_q[$];
  pixel_t sb_q[$];
  bit     mdl_ovf;
  int     mdl_drops;
  pixel_t mdl_last;
  bit     mdl_last_valid;

  task automatic check_field(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mdl_q.delete();
    sb_q.delete();
    mdl_ovf        = 1'b0;
    mdl_drops      = 0;
    mdl_last_valid = 1'b0;
  endtask

  // Drives one cycle of inputs and advances the model to the post-edge state.
  task automatic applyStimulus(input bit p, input int x, input int y, input int c,
                               input bit q, input bit clr);
    pixel_t pkt;
    bit     popped, dup;
    push     = p;
    x_in     = 8'(x);
    y_in     = 8'(y);
    color_in = 3'(c);
    pop      = q;
    clear    = clr;
    pkt      = '{x: 8'(x), y: 8'(y), colour: 3'(c)};
    if (clr) begin
      model_reset();
    end else begin
      popped = q && (mdl_q.size() > 0);
      dup    = mdl_last_valid && (pkt == mdl_last);
      if (popped) void'(mdl_q.pop_front());
      if (p && !dup) begin
        if (mdl_q.size() < DEPTH) begin
          mdl_q.push_back(pkt);
          sb_q.push_back(pkt);
          mdl_last       = pkt;
          mdl_last_valid = 1'b1;
        end else begin
          mdl_ovf = 1'b1;
          if (mdl_drops < 255) mdl_drops++;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput();
    check_field("count", int'(count), mdl_q.size());
    check_field("full", int'(full), int'(mdl_q.size() == DEPTH));
    check_field("head_valid", int'(head_valid), int'(mdl_q.size() != 0));
    check_field("overflow", int'(overflow), int'(mdl_ovf));
    check_field("drop_count", int'(drop_count), mdl_drops);
    if (mdl_q.size() != 0) begin
      check_field("head_pkt", int'({x_out, y_out, color_out}), int'(mdl_q[0]));
    end else begin
      check_field("empty_head", int'({x_out, y_out, color_out}), 0);
    end
  endtask

  task automatic cycle(input bit p, input int x, input int y, input int c,
                       input bit q, input bit clr);
    applyStimulus(p, x, y, c, q, clr);
    checkOutput();
  endtask

  // Monitor: every pop the DUT honours must deliver the oldest expected packet.
  always @(negedge clk) begin
    if (rst_n && pop && !clear && head_valid) begin
      if (sb_q.size() == 0) begin
        bad++;
        total++;
        $display("[TB] FAIL pop_order: got %0d expected no entry at %0t",
                 {x_out, y_out, color_out}, $time);
      end else begin
        pixel_t exp_pkt;
        exp_pkt = sb_q.pop_front();
        total++;
        if ({x_out, y_out, color_out} != exp_pkt) begin
          bad++;
          $display("[TB] FAIL pop_order: got %0d/%0d/%0d expected %0d/%0d/%0d at %0t",
                   x_out, y_out, color_out, exp_pkt.x, exp_pkt.y, exp_pkt.colour, $time);
        end
      end
    end
  end

  initial begin
    model_reset();
    #12;
    checkOutput();
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single push appears at the head one cycle later.
    cycle(1, 10, 20, 5, 0, 0);
    check_field("t1_x", int'(x_out), 10);
    check_field("t1_color", int'(color_out), 5);

    // Held push collapses to one entry; a colour change is a new packet.
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) cycle(1, 5, 5, 1, 0, 0);
    check_field("t2_count_dup", int'(count), 1);
    cycle(1, 5, 5, 2, 0, 0);
    check_field("t2_count_new", int'(count), 2);

    // Fill, then overflow with a ninth packet.
    cycle(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < DEPTH; i++) cycle(1, 30 + i, 40 + i, i % 8, 0, 0);
    cycle(1, 7, 7, 7, 0, 0);
    check_field("t3_drop", int'(drop_count), 1);
    check_field("t3_head_x", int'(x_out), 30);

    // Push and pop together on a full queue, then drain.
    cycle(1, 9, 9, 1, 1, 0);
    check_field("t4_count", int'(count), DEPTH);
    for (int i = 0; i < DEPTH; i++) cycle(0, 0, 0, 0, 1, 0);

    // Interleaved traffic forcing pointer wrap.
    for (int i = 0; i < 12; i++) cycle(1, 100 + i, i, i % 8, (i % 3) != 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) cycle(0, 0, 0, 0, 1, 0);
    check_field("t5_count", int'(count), 0);

    // Clear with push beats everything; the last packet can then be re-pushed.
    for (int i = 0; i < DEPTH; i++) cycle(1, 50 + i, 60, 2, 0, 0);
    cycle(1, 1, 2, 3, 0, 0);
    for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0);
    check_field("t6_count_before", int'(count), 3);
    cycle(1, 57, 60, 2, 1, 1);
    check_field("t6_overflow", int'(overflow), 0);
    cycle(1, 57, 60, 2, 0, 0);
    check_field("t6_repush", int'(count), 1);

    // Random traffic over a small value range so duplicates and losses occur.
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(99) < 60, $urandom_range(3), $urandom_range(3),
            $urandom_range(3), $urandom_range(99) < 40, $urandom_range(99) < 2);
    end
    for (int i = 0; i < DEPTH + 1; i++) cycle(0, 0, 0, 0, 1, 0);
    check_field("final_sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
